pcie_rx_credit_ret: RTL and testbench
=====================================

// Module: pcie_rx_credit_ret
// PURPOSE
//  Receive-side flow-control credit return for the ECP3 PCIe core (VC0).
//  Snoops the core's RX TLP stream, classifies each TLP (posted, non-posted
//  or completion), computes its header/data credits and drives the core's
//  ph/pd/nph/npd_processed pulses plus pd_num.
//  Credits return either at TLP end or on a consumer release; a small queue
//  holds TLPs whose credits are still pending.
// PARAMETERS
//  REL_MODE    0  0: credits queued at rx_end; 1: credits wait for rel pulse
//  QDEPTH      8  pending-return queue entries (power of 2, 2..32)
// PORTS
//  clk_125     in   1   system clock, 125 MHz
//  rstn        in   1   async reset, active-low
//  rx_st       in   1   first 16-bit word of TLP valid
//  rx_end      in   1   last word of TLP valid
//  rx_data     in   16  TLP word stream
//  rel         in   1   consumer released oldest TLP (REL_MODE=1 only)
//  ph_cr       out  1   posted header credit pulse
//  pd_cr       out  1   posted data credit pulse, qualified by pd_num
//  pd_num      out  8   posted data credits returned with pd_cr
//  nph_cr      out  1   non-posted header credit pulse
//  npd_cr      out  1   non-posted data credit pulse (always 1 credit)
//  q_level     out  6   occupied queue entries
//  q_full      out  1   q_level == QDEPTH
//  err         out  1   sticky: overflow or framing error
// BEHAVIOUR
//  Reset is asynchronous, active-low, on rstn; clock is clk_125.
//  Reset: all pulses 0, pd_num 0, q_level 0, q_full 0, err 0, FSMs idle.
//  Reset mid-TLP: the partial TLP is discarded and no credit is returned.
//  Parser FSM: P_IDLE -> P_W1 -> P_BODY -> P_IDLE.
//  - P_IDLE: on rx_st, latch fmt=rx_data[14:13], type=rx_data[12:8].
//  - P_IDLE: rx_st and rx_end in the same cycle is a framing error.
//    The TLP is dropped, err is set and the FSM stays in P_IDLE.
//  - P_W1: next word, latch len=rx_data[9:0]; go to P_BODY (P_IDLE if rx_end).
//  - P_BODY: on rx_end, build the entry and go to P_IDLE.
//  - rx_st seen in P_W1/P_BODY: abort the old TLP (no credit) and set err.
//    The new TLP starts from its word0.
//  Classification (fmt[1] = has data):
//  - type 00000/00001 (Mem): fmt[1] ? posted-with-data : NP.
//  - type 10xxx (Msg): posted; with data if fmt[1].
//  - type 00010/00100/00101 (IO/Cfg): NP; fmt[1] adds one NPD credit.
//  - type 0101x (Cpl) and all others: class NONE, nothing enqueued.
//  Data credits, 9-bit: dcred = (len==0) ? 256 : (len+3)>>2.
//  Queue: FIFO of {class[1:0], dcred[8:0]}, QDEPTH entries.
//  - Write one cycle after rx_end.
//  - Full on write: entry dropped and err set; q_level stays at QDEPTH.
//  - A simultaneous write and read is allowed at full; the write is accepted.
//  Return FSM: R_IDLE -> R_ISSUE -> (R_SPLIT) -> R_IDLE.
//  - REL_MODE 0: pops the head entry as soon as the queue is non-empty.
//  - REL_MODE 1: pops only on rel; rel with an empty queue is ignored.
//    Each rel is counted, up to QDEPTH outstanding.
//  - R_ISSUE, one-cycle pulses:
//    posted: ph_cr=1; if data, pd_cr=1 and pd_num=min(dcred,255).
//    NP: nph_cr=1; npd_cr=1 if it has data.
//  - dcred==256: R_SPLIT next cycle drives pd_cr=1, pd_num=1.
//  - pd_num holds its value between pulses.
//  - At most one return per cycle; back-to-back entries return on consecutive
//    cycles.
//  Latency, REL_MODE 0, empty queue: rx_end at cycle N -> enqueue at N+1,
//  credit pulse at N+2.
//  Latency, REL_MODE 1: rel at cycle M -> credit pulse at M+1.
// TESTING
//  MWr len=32 (fmt=10, type=0) -> 2 cycles after rx_end:
//    ph_cr=pd_cr=1, pd_num=8 for one cycle.
//  MWr len=0 -> pd_cr with pd_num=255, next cycle pd_cr with pd_num=1;
//    ph_cr only on the first pulse.
//  MRd len=1 -> nph_cr only; CfgWr0 -> nph_cr=npd_cr=1 in the same cycle;
//    CplD -> no pulses.
//  REL_MODE=1, 9 MWr with no rel -> q_full=1, err=1, q_level=8;
//    then 8 rel pulses -> 8 returns, q_level=0.
//  rx_st re-asserted mid-body, and rx_st&rx_end together -> err=1;
//    only valid TLPs credited.
//  rstn low during P_BODY with 3 queued entries -> all outputs 0,
//    no later pulses for those TLPs.

Source files
------------

// File: rtl/pcie_rx_credit_ret_if.sv
// pcie_rx_credit_ret_if
//   Bundles the RX TLP snoop stream and the flow-control credit return
//   pulses that travel between the PCIe core and pcie_rx_credit_ret.
//   master : drives the TLP stream and rel, observes the credit pulses
//   slave  : the credit-return block itself
//   rx_st / rx_end  first / last word of a TLP
//   rx_data         16-bit TLP word stream
//   rel             consumer released the oldest TLP (release mode only)
//   ph_cr, pd_cr    posted header / data credit pulses, pd_num = data credits
//   nph_cr, npd_cr  non-posted header / data credit pulses
interface pcie_rx_credit_ret_if;
  logic        rx_st;
  logic        rx_end;
  logic [15:0] rx_data;
  logic        rel;
  logic        ph_cr;
  logic        pd_cr;
  logic [7:0]  pd_num;
  logic        nph_cr;
  logic        npd_cr;

  modport master (
    output rx_st, rx_end, rx_data, rel,
    input  ph_cr, pd_cr, pd_num, nph_cr, npd_cr
  );

  modport slave (
    input  rx_st, rx_end, rx_data, rel,
    output ph_cr, pd_cr, pd_num, nph_cr, npd_cr
  );
endinterface

// File: rtl/pcie_rx_credit_ret.sv
// pcie_rx_credit_ret
//   Receive-side VC0 flow-control credit return for the ECP3 PCIe core.
//   Snoops the RX TLP stream, classifies each TLP as posted, non-posted or
//   neither, computes its header/data credits and queues it. A return FSM
//   pops the queue and pulses the core's credit-processed inputs, either as
//   soon as an entry is queued (REL_MODE 0) or on consumer release (REL_MODE 1).
// Ports
//   clk_125   125 MHz clock
//   rstn      asynchronous active-low reset
//   bus       slave side of pcie_rx_credit_ret_if (TLP stream, rel, credits)
//   q_level   occupied pending-return queue entries
//   q_full    queue holds QDEPTH entries
//   err       sticky overflow / framing error
module pcie_rx_credit_ret #(
  parameter int REL_MODE = 0,
  parameter int QDEPTH   = 8
) (
  input  logic                       clk_125,
  input  logic                       rstn,
  pcie_rx_credit_ret_if.slave        bus,
  output logic [5:0]                 q_level,
  output logic                       q_full,
  output logic                       err
);
  localparam int         PW       = $clog2(QDEPTH);
  localparam logic [5:0] QDEPTH_L = 6'(QDEPTH);
  localparam logic [1:0] C_NONE   = 2'd0;
  localparam logic [1:0] C_POST   = 2'd1;
  localparam logic [1:0] C_NP     = 2'd2;

  typedef enum logic [1:0] {P_IDLE, P_W1, P_BODY} p_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_SPLIT} r_state_t;

  p_state_t      p_state_q, p_state_d;
  r_state_t      r_state_q, r_state_d;
  logic [1:0]    fmt_q, fmt_d;
  logic [4:0]    type_q, type_d;
  logic [9:0]    len_q, len_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [5:0]    q_level_q, q_level_d, rel_cnt_q, rel_cnt_d;
  logic          err_q, err_d, split_q, split_d;
  logic          ph_cr_q, ph_cr_d, pd_cr_q, pd_cr_d;
  logic          nph_cr_q, nph_cr_d, npd_cr_q, npd_cr_d;
  logic [7:0]    pd_num_q, pd_num_d;
  logic [10:0]   mem_q [QDEPTH];

  logic          tlp_done, frame_err, wr_req, wr_acc, pop, full, rel_take;
  logic [1:0]    new_class;
  logic [9:0]    new_len;
  logic [10:0]   len_p3;
  logic [8:0]    new_dcred;
  logic [10:0]   head;
  logic [5:0]    rel_sum;
  logic          unused_rx;

  assign unused_rx = bus.rx_data[15];

  function automatic logic [1:0] classify(input logic [1:0] f, input logic [4:0] t);
    logic [1:0] c;
    if (t == 5'b00000 || t == 5'b00001)                    c = f[1] ? C_POST : C_NP;
    else if (t[4:3] == 2'b10)                              c = C_POST;
    else if (t == 5'b00010 || t == 5'b00100 || t == 5'b00101) c = C_NP;
    else                                                   c = C_NONE;
    return c;
  endfunction

  // Parser: an rx_st while a TLP is still open aborts it and restarts from
  // the new word0; rx_st together with rx_end never opens a TLP.
  always_comb begin
    p_state_d = p_state_q;
    fmt_d     = fmt_q;
    type_d    = type_q;
    len_d     = len_q;
    tlp_done  = 1'b0;
    frame_err = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        if (bus.rx_st) begin
          if (bus.rx_end) begin
            frame_err = 1'b1;
          end else begin
            fmt_d     = bus.rx_data[14:13];
            type_d    = bus.rx_data[12:8];
            p_state_d = P_W1;
          end
        end
      end
      default: begin
        if (bus.rx_st) begin
          frame_err = 1'b1;
          if (bus.rx_end) begin
            p_state_d = P_IDLE;
          end else begin
            fmt_d     = bus.rx_data[14:13];
            type_d    = bus.rx_data[12:8];
            p_state_d = P_W1;
          end
        end else if (p_state_q == P_W1) begin
          len_d = bus.rx_data[9:0];
          if (bus.rx_end) begin
            tlp_done  = 1'b1;
            p_state_d = P_IDLE;
          end else begin
            p_state_d = P_BODY;
          end
        end else if (bus.rx_end) begin
          tlp_done  = 1'b1;
          p_state_d = P_IDLE;
        end
      end
    endcase
  end

  // Entry build: a 2-word TLP ending in P_W1 takes its length straight from
  // the bus. A zero dcred in an entry means "no data credits".
  always_comb begin
    new_class = classify(fmt_q, type_q);
    new_len   = (p_state_q == P_W1) ? bus.rx_data[9:0] : len_q;
    len_p3    = {1'b0, new_len} + 11'd3;
    new_dcred = !fmt_q[1] ? 9'd0 : ((new_len == 10'd0) ? 9'd256 : len_p3[10:2]);
    wr_req    = tlp_done && (new_class != C_NONE);
  end

  // Queue and return FSM. A 256-credit posted entry needs a second pd pulse,
  // so no pop is allowed in the R_ISSUE cycle that precedes R_SPLIT.
  always_comb begin
    full     = (q_level_q == QDEPTH_L);
    head     = mem_q[rd_ptr_q];
    rel_take = (REL_MODE != 0) && bus.rel && (q_level_q != 6'd0);
    pop      = (q_level_q != 6'd0) && !(r_state_q == R_ISSUE && split_q) &&
               ((REL_MODE == 0) || rel_take || (rel_cnt_q != 6'd0));
    wr_acc   = wr_req && (!full || pop);

    wr_ptr_d  = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    q_level_d = q_level_q + 6'(wr_acc) - 6'(pop);
    err_d     = err_q | frame_err | (wr_req && !wr_acc);

    rel_sum   = rel_cnt_q + 6'(rel_take) - 6'(pop);
    rel_cnt_d = (REL_MODE == 0) ? 6'd0 : ((rel_sum > QDEPTH_L) ? QDEPTH_L : rel_sum);

    r_state_d = R_IDLE;
    split_d   = 1'b0;
    ph_cr_d   = 1'b0;
    pd_cr_d   = 1'b0;
    nph_cr_d  = 1'b0;
    npd_cr_d  = 1'b0;
    pd_num_d  = pd_num_q;
    if (r_state_q == R_ISSUE && split_q) begin
      r_state_d = R_SPLIT;
      pd_cr_d   = 1'b1;
      pd_num_d  = 8'd1;
    end else if (pop) begin
      r_state_d = R_ISSUE;
      if (head[10:9] == C_POST) begin
        ph_cr_d = 1'b1;
        if (head[8:0] != 9'd0) begin
          pd_cr_d  = 1'b1;
          pd_num_d = head[8] ? 8'd255 : head[7:0];
          split_d  = head[8];
        end
      end else begin
        nph_cr_d = 1'b1;
        npd_cr_d = (head[8:0] != 9'd0);
      end
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      p_state_q <= P_IDLE;
      r_state_q <= R_IDLE;
      fmt_q     <= 2'd0;
      type_q    <= 5'd0;
      len_q     <= 10'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_level_q <= 6'd0;
      rel_cnt_q <= 6'd0;
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      ph_cr_q   <= 1'b0;
      pd_cr_q   <= 1'b0;
      nph_cr_q  <= 1'b0;
      npd_cr_q  <= 1'b0;
      pd_num_q  <= 8'd0;
    end else begin
      p_state_q <= p_state_d;
      r_state_q <= r_state_d;
      fmt_q     <= fmt_d;
      type_q    <= type_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      q_level_q <= q_level_d;
      rel_cnt_q <= rel_cnt_d;
      err_q     <= err_d;
      split_q   <= split_d;
      ph_cr_q   <= ph_cr_d;
      pd_cr_q   <= pd_cr_d;
      nph_cr_q  <= nph_cr_d;
      npd_cr_q  <= npd_cr_d;
      pd_num_q  <= pd_num_d;
    end
  end

  // Queue storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk_125) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {new_class, new_dcred};
  end

  assign bus.ph_cr  = ph_cr_q;
  assign bus.pd_cr  = pd_cr_q;
  assign bus.pd_num = pd_num_q;
  assign bus.nph_cr = nph_cr_q;
  assign bus.npd_cr = npd_cr_q;
  assign q_level    = q_level_q;
  assign q_full     = full;
  assign err        = err_q;
endmodule

// File: tb/tb_pcie_rx_credit_ret.sv
// tb_pcie_rx_credit_ret
//   Directed bench for pcie_rx_credit_ret. dut0 returns credits at TLP end,
//   dut1 waits for rel pulses; both see the same TLP stream.
module tb_pcie_rx_credit_ret;
  logic        clk_125 = 1'b0;
  logic        rstn;
  logic        rx_st, rx_end, rel;
  logic [15:0] rx_data;
  logic [5:0]  q_level0, q_level1;
  logic        q_full0, q_full1, err0, err1;
  int          checks = 0;
  int          errors = 0;

  pcie_rx_credit_ret_if bus0();
  pcie_rx_credit_ret_if bus1();

  assign bus0.rx_st   = rx_st;
  assign bus0.rx_end  = rx_end;
  assign bus0.rx_data = rx_data;
  assign bus0.rel     = 1'b0;
  assign bus1.rx_st   = rx_st;
  assign bus1.rx_end  = rx_end;
  assign bus1.rx_data = rx_data;
  assign bus1.rel     = rel;

  pcie_rx_credit_ret #(.REL_MODE(0), .QDEPTH(8)) dut0 (
    .clk_125(clk_125), .rstn(rstn), .bus(bus0),
    .q_level(q_level0), .q_full(q_full0), .err(err0)
  );

  pcie_rx_credit_ret #(.REL_MODE(1), .QDEPTH(8)) dut1 (
    .clk_125(clk_125), .rstn(rstn), .bus(bus1),
    .q_level(q_level1), .q_full(q_full1), .err(err1)
  );

  always #4 clk_125 = ~clk_125;

  // Packs every observable output into one vector:
  // {ph, pd, nph, npd, pd_num[7:0], q_level[5:0], q_full, err}
  function automatic logic [19:0] pack(input logic ph, input logic pd,
                                       input logic nph, input logic npd,
                                       input logic [7:0] num, input logic [5:0] lvl,
                                       input logic full, input logic e);
    return {ph, pd, nph, npd, num, lvl, full, e};
  endfunction

  function automatic logic [19:0] snap0();
    return pack(bus0.ph_cr, bus0.pd_cr, bus0.nph_cr, bus0.npd_cr, bus0.pd_num,
                q_level0, q_full0, err0);
  endfunction

  function automatic logic [19:0] snap1();
    return pack(bus1.ph_cr, bus1.pd_cr, bus1.nph_cr, bus1.npd_cr, bus1.pd_num,
                q_level1, q_full1, err1);
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] observed,
                             input logic [19:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic drive(input logic st, input logic en, input logic [15:0] data);
    rx_st   = st;
    rx_end  = en;
    rx_data = data;
    tick();
  endtask

  // word0, length word, then a final word carrying rx_end
  task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] len);
    drive(1'b1, 1'b0, w0);
    drive(1'b0, 1'b0, len);
    drive(1'b0, 1'b1, 16'h0000);
    rx_st   = 1'b0;
    rx_end  = 1'b0;
    rx_data = 16'h0000;
  endtask

  initial begin
    rstn    = 1'b0;
    rx_st   = 1'b0;
    rx_end  = 1'b0;
    rx_data = 16'h0000;
    rel     = 1'b0;
    #20;
    checkOutput("rst0", snap0(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    checkOutput("rst1", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    tick();
    rstn = 1'b1;
    tick();

    // MWr len=32 -> 8 data credits, two cycles after rx_end
    applyStimulus(16'h4000, 16'd32);
    checkOutput("mwr32_enq", snap0(), pack(0, 0, 0, 0, 8'd0, 6'd1, 0, 0));
    tick();
    checkOutput("mwr32_pulse", snap0(), pack(1, 1, 0, 0, 8'd8, 6'd0, 0, 0));
    tick();
    checkOutput("mwr32_after", snap0(), pack(0, 0, 0, 0, 8'd8, 6'd0, 0, 0));

    // MWr len=0 -> 256 credits split as 255 + 1
    applyStimulus(16'h4000, 16'd0);
    tick();
    checkOutput("mwr0_first", snap0(), pack(1, 1, 0, 0, 8'd255, 6'd0, 0, 0));
    tick();
    checkOutput("mwr0_split", snap0(), pack(0, 1, 0, 0, 8'd1, 6'd0, 0, 0));
    tick();
    checkOutput("mwr0_after", snap0(), pack(0, 0, 0, 0, 8'd1, 6'd0, 0, 0));

    // MRd len=1 -> nph only
    applyStimulus(16'h0000, 16'd1);
    tick();
    checkOutput("mrd", snap0(), pack(0, 0, 1, 0, 8'd1, 6'd0, 0, 0));

    // CfgWr0 -> nph and npd together
    applyStimulus(16'h4400, 16'd1);
    tick();
    checkOutput("cfgwr0", snap0(), pack(0, 0, 1, 1, 8'd1, 6'd0, 0, 0));

    // CplD -> nothing queued, nothing returned
    applyStimulus(16'h4A00, 16'd4);
    checkOutput("cpld_enq", snap0(), pack(0, 0, 0, 0, 8'd1, 6'd0, 0, 0));
    tick();
    checkOutput("cpld_none", snap0(), pack(0, 0, 0, 0, 8'd1, 6'd0, 0, 0));

    // MsgD len=12 -> posted with (12+3)>>2 = 3 data credits
    applyStimulus(16'h7000, 16'd12);
    tick();
    checkOutput("msgd", snap0(), pack(1, 1, 0, 0, 8'd3, 6'd0, 0, 0));

    // rx_st with rx_end in idle is a framing error, nothing credited
    drive(1'b1, 1'b1, 16'h4000);
    rx_st  = 1'b0;
    rx_end = 1'b0;
    checkOutput("frame_err", snap0(), pack(0, 0, 0, 0, 8'd3, 6'd0, 0, 1));
    tick();
    tick();
    checkOutput("frame_nocred", snap0(), pack(0, 0, 0, 0, 8'd3, 6'd0, 0, 1));

    // MWr aborted mid-body by an MRd; only the MRd is credited
    drive(1'b1, 1'b0, 16'h4000);
    drive(1'b0, 1'b0, 16'd4);
    drive(1'b0, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 16'd1);
    checkOutput("abort_enq", snap0(), pack(0, 0, 0, 0, 8'd3, 6'd1, 0, 1));
    tick();
    checkOutput("abort_mrd", snap0(), pack(0, 0, 1, 0, 8'd3, 6'd0, 0, 1));

    // Release mode: 9 MWr without rel overflow the 8-entry queue
    rstn = 1'b0;
    #2;
    checkOutput("rst_b", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) applyStimulus(16'h4000, 16'd4);
    checkOutput("fill", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd8, 1, 1));
    rel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("rel%0d", i), snap1(),
                  pack(1, 1, 0, 0, 8'd1, 6'(7 - i), 0, 1));
    end
    rel = 1'b0;
    tick();
    checkOutput("rel_done", snap1(), pack(0, 0, 0, 0, 8'd1, 6'd0, 0, 1));
    rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    checkOutput("rel_empty", snap1(), pack(0, 0, 0, 0, 8'd1, 6'd0, 0, 1));

    // Reset during P_BODY with 3 entries queued discards everything
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) applyStimulus(16'h4000, 16'd4);
    checkOutput("c_queued", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd3, 0, 0));
    drive(1'b1, 1'b0, 16'h4000);
    drive(1'b0, 1'b0, 16'd4);
    drive(1'b0, 1'b0, 16'h0000);
    rstn = 1'b0;
    #2;
    checkOutput("c_rst1", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    checkOutput("c_rst0", snap0(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    rstn = 1'b1;
    drive(1'b0, 1'b1, 16'h0000);
    rx_end = 1'b0;
    rel    = 1'b1;
    tick();
    checkOutput("c_rel_a", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    tick();
    tick();
    rel = 1'b0;
    tick();
    checkOutput("c_rel_b", snap1(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));
    checkOutput("c_none0", snap0(), pack(0, 0, 0, 0, 8'd0, 6'd0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
